// File: rtl/physical_transmitter.sv
// QPSK symbol mapper with rectangular NRZ upsampling (SPS identical beats per symbol), AXIS in and out.
// Define TX_PREAMBLE_EN to prepend PREAMBLE_LEN alternating 00/11 symbols at every burst start.
module physical_transmitter #(
    parameter int                 SPS          = 4,
    parameter logic signed [11:0] AMP          = 12'sd1024,
    parameter int                 PREAMBLE_LEN = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [1:0]  in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [23:0] out_data,
    input  logic        out_ready
);
    localparam int               CNT_W     = $clog2(SPS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(SPS - 1);
    localparam logic [11:0]      LVL_POS   = AMP;
    localparam logic [11:0]      LVL_NEG   = -AMP;

    if (SPS < 2 || SPS > 64) begin : g_bad_sps
        $error("physical_transmitter: SPS must be 2..64");
    end
    if (AMP < 12'sd1) begin : g_bad_amp
        $error("physical_transmitter: AMP must be 1..2047");
    end
    if (PREAMBLE_LEN < 1 || PREAMBLE_LEN > 255) begin : g_bad_preamble_len
        $error("physical_transmitter: PREAMBLE_LEN must be 1..255");
    end

`ifdef TX_PREAMBLE_EN
    typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_DATA} state_t;
    localparam logic [7:0] LAST_PRE = 8'(PREAMBLE_LEN - 1);
    logic [7:0] r_pre_cnt;
`else
    typedef enum logic [1:0] {S_IDLE, S_DATA} state_t;
`endif

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pend_valid;
    logic [1:0]       r_pend_data;
    logic [1:0]       r_sym;
    logic [1:0]       w_sym_out;
    logic             w_beat;
    logic             w_last_beat;
    logic             w_accept;
    logic             w_load;

    // in_ready is held low during reset so no symbol is taken before the FSM is clean.
    assign in_ready    = rst && !r_pend_valid;
    assign w_accept    = in_valid && in_ready;
    assign w_beat      = out_valid && out_ready;
    assign w_last_beat = w_beat && (r_cnt == LAST_BEAT);
    // Pending symbol moves into the current-symbol register whenever DATA starts a new symbol.
    assign w_load      = r_pend_valid && (w_next_state == S_DATA) &&
                         ((r_state != S_DATA) || w_last_beat);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_pend_valid) begin
`ifdef TX_PREAMBLE_EN
                    w_next_state = S_PREAMBLE;
`else
                    w_next_state = S_DATA;
`endif
                end
            end
`ifdef TX_PREAMBLE_EN
            S_PREAMBLE: begin
                if (w_last_beat && (r_pre_cnt == LAST_PRE)) begin
                    w_next_state = S_DATA;
                end
            end
`endif
            S_DATA: begin
                if (w_last_beat && !r_pend_valid) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        w_sym_out = 2'b00;
        case (r_state)
`ifdef TX_PREAMBLE_EN
            S_PREAMBLE: begin
                out_valid = 1'b1;
                w_sym_out = {2{r_pre_cnt[0]}};
            end
`endif
            S_DATA: begin
                out_valid = 1'b1;
                w_sym_out = r_sym;
            end
            default: begin
                out_valid = 1'b0;
                w_sym_out = 2'b00;
            end
        endcase
        out_data = 24'h0;
        if (out_valid) begin
            out_data = {w_sym_out[1] ? LVL_NEG : LVL_POS,
                        w_sym_out[0] ? LVL_NEG : LVL_POS};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt        <= '0;
            r_pend_valid <= 1'b0;
            r_pend_data  <= 2'b00;
            r_sym        <= 2'b00;
        end else begin
            if (w_beat) begin
                r_cnt <= (r_cnt == LAST_BEAT) ? '0 : r_cnt + 1'b1;
            end
            if (w_load) begin
                r_pend_valid <= 1'b0;
                r_sym        <= r_pend_data;
            end else if (w_accept) begin
                r_pend_valid <= 1'b1;
                r_pend_data  <= in_data;
            end
        end
    end

`ifdef TX_PREAMBLE_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pre_cnt <= 8'd0;
        end else if ((r_state == S_PREAMBLE) && w_last_beat) begin
            r_pre_cnt <= (r_pre_cnt == LAST_PRE) ? 8'd0 : r_pre_cnt + 8'd1;
        end
    end
`endif

endmodule
